vga_config_sequencer: RTL and testbench
=======================================

# vga_config_sequencer

Configuration master for the VGA timing controller. Drives its `C_valid`/`C_addr`/`C_data`/`C_rdy` configuration port. After reset, and on each `start` pulse, it writes one of two preset timing sets (8 registers). Between loads it arbitrates a host write port onto the same configuration bus. A per-write timeout flags a stalled controller.

## Interface
- `CONFIG_WIDTH`, 12: width of `C_addr`, `C_data`, `H_addr`, `H_data`.
- `TIMEOUT`, 64: maximum consecutive cycles a write may wait for `C_rdy`.
- `Clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-high (asserted = 1, despite the name).
- `start` in 1: one-cycle pulse requesting a preset load; honoured only in IDLE.
- `mode_sel` in 1: preset select, latched when reset is released and on an accepted `start`.
- `H_valid` in 1: host write request.
- `H_addr` in CONFIG_WIDTH: host register address.
- `H_data` in CONFIG_WIDTH: host register data.
- `H_rdy` out 1: host write accepted this cycle.
- `C_valid` out 1: configuration write valid to the VGA controller.
- `C_addr` out CONFIG_WIDTH: configuration address.
- `C_data` out CONFIG_WIDTH: configuration data.
- `C_rdy` in 1: VGA controller accepts the write.
- `busy` out 1: preset load in progress.
- `done` out 1: one-cycle pulse after a successful load.
- `cfg_err` out 1: sticky timeout flag.

## Operation
- Register map, entry index = address:
  - 0 H_Left_Margin
  - 1 V_Left_Margin
  - 2 H_Right_Margin
  - 3 V_Right_Margin
  - 4 H_Sync_Pulse
  - 5 V_Sync_Pulse
  - 6 H_Count_Max
  - 7 V_Count_Max
- Preset, mode 0 (simulation test mode), entries 0..7: 1, 2, 7, 8, 1, 0, 10, 12.
- Preset, mode 1 (640x480), entries 0..7: 48, 33, 16, 10, 96, 2, 800, 525.
- States:
  - BOOT: reset held. Next: LOAD.
  - LOAD: `C_valid` = 1, `C_addr` = idx, `C_data` = table[mode][idx].
    - On `C_valid && C_rdy` at an edge: idx+1.
    - If idx was 7: go to IDLE and pulse `done`.
    - On timeout: go to IDLE, set `cfg_err`, no `done`.
  - IDLE: host pass-through. `C_valid` = `H_valid`, `C_addr`/`C_data` = `H_addr`/`H_data`, `H_rdy` = `C_rdy && H_valid`.
    - `start` → LOAD with idx = 0. Latch `mode_sel`, clear `cfg_err`.
- Handshake: the `C_addr`/`C_data` pair is held stable while `C_valid && !C_rdy`. A transfer occurs only at an edge where both `C_valid` and `C_rdy` are high.
- `start` and `H_valid` in the same IDLE cycle: `start` wins. `C_valid` is forced to 0 and `H_rdy` to 0 that cycle, and the host retries later.
- `H_rdy` = 0 in BOOT and LOAD.
- `start` during LOAD or BOOT is ignored.
- Timeout counter: cleared on each handshake and on entry to LOAD. It increments each LOAD cycle with `!C_rdy`. When the count reaches TIMEOUT, the next state is IDLE. The counter is `$clog2(TIMEOUT+1)` bits and saturates.

## Timing
- Reset values while `rst_n` = 1:
  - state BOOT, idx 0
  - `C_valid` = 0, `C_addr` = 0, `C_data` = 0
  - `H_rdy` = 0, `busy` = 0, `done` = 0, `cfg_err` = 0
- First edge with `rst_n` = 0: state becomes LOAD. `C_valid` and `busy` go to 1 in that cycle.
- `rst_n` asserted mid-load: abort immediately at that edge with no partial `done`. The full boot load restarts after release.
- LOAD outputs (`C_valid`, `C_addr`, `C_data`, `busy`) decode from registered state and idx. They change only at edges.
- IDLE outputs are a combinational mux of the host port (zero latency).
- With `C_rdy` constantly 1, LOAD lasts exactly 8 cycles. `done` is high for the cycle after the 8th handshake, together with `busy` = 0.
- Load → IDLE → `start` → LOAD: one IDLE cycle minimum. `start` is sampled at an edge and LOAD begins the next cycle.
- `cfg_err` sets in the cycle after the timeout edge. It stays set until an accepted `start` or reset.

## Structure
- Shared parameter include holds:
  - register address constants (8 names above)
  - the two preset value sets
  - state encodings: BOOT = 2'd0, LOAD = 2'd1, IDLE = 2'd2
- Sub-module `vga_timing_rom`: combinational table indexed by {mode, idx[2:0]}, returning CONFIG_WIDTH data.
- Top level holds the FSM, idx counter, timeout counter, mode latch and host mux.

## Test plan
- Reset released, `mode_sel` = 0, `C_rdy` = 1 → 8 consecutive cycles with `C_addr` 0..7 and `C_data` 1,2,7,8,1,0,10,12. Then `done` pulses once and `busy` falls.
- `mode_sel` = 1, `start` in IDLE, `C_rdy` toggling 1-of-3 cycles → every `C_addr`/`C_data` pair held until handshake. Data sequence 48,33,16,10,96,2,800,525, then `done`.
- `C_rdy` held 0 from entry 3 → `C_addr` = 3 stable for 64 cycles, then IDLE, `cfg_err` = 1, no `done`. A subsequent `start` clears `cfg_err`.
- In IDLE, `H_valid` = 1 with addr 6, data 640, and `C_rdy` = 1 → same-cycle pass-through, `H_rdy` = 1. During LOAD, `H_valid` = 1 → `H_rdy` = 0 throughout.
- `start` and `H_valid` in the same cycle → `C_valid` = 0 and `H_rdy` = 0 that cycle. Next cycle is LOAD with `C_addr` = 0.
- `rst_n` pulsed high at entry 5 of a load → outputs at reset values. After release, a full load restarts from `C_addr` = 0.

Source files
------------

// File: rtl/vga_config_sequencer_pkg.sv
// Shared definitions for the VGA configuration sequencer.
// Holds the configuration register map, the two preset timing sets,
// the sequencer state encoding and the preset lookup used by the ROM.
package vga_config_sequencer_pkg;

  // Configuration register map: the entry index is the register address.
  typedef enum logic [2:0] {
    H_LEFT_MARGIN  = 3'd0,
    V_LEFT_MARGIN  = 3'd1,
    H_RIGHT_MARGIN = 3'd2,
    V_RIGHT_MARGIN = 3'd3,
    H_SYNC_PULSE   = 3'd4,
    V_SYNC_PULSE   = 3'd5,
    H_COUNT_MAX    = 3'd6,
    V_COUNT_MAX    = 3'd7
  } cfg_reg_e;

  // Mode 0: small simulation test timing.
  localparam int unsigned PRESET_TEST [8]    = '{1, 2, 7, 8, 1, 0, 10, 12};
  // Mode 1: 640x480 timing.
  localparam int unsigned PRESET_640X480 [8] = '{48, 33, 16, 10, 96, 2, 800, 525};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    IDLE = 2'd2
  } state_e;

  // sel = {mode, idx[2:0]}
  function automatic int unsigned preset_value(input logic [3:0] sel);
    if (sel[3]) return PRESET_640X480[sel[2:0]];
    else        return PRESET_TEST[sel[2:0]];
  endfunction

endpackage

// File: rtl/vga_config_sequencer_if.sv
// Valid/ready register-write port: one address/data pair per handshake.
// master drives valid/addr/data and samples rdy; slave is the reverse.
interface vga_config_sequencer_if #(
  parameter int unsigned WIDTH = 12
) ();
  logic             valid;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] data;
  logic             rdy;

  modport master (output valid, output addr, output data, input rdy);
  modport slave  (input valid, input addr, input data, output rdy);
endinterface

// File: rtl/vga_config_sequencer_rom.sv
// vga_timing_rom: combinational preset table.
// Ports: mode (preset select), idx (register address 0..7),
//        data (CONFIG_WIDTH-bit preset value for {mode, idx}).
module vga_timing_rom
  import vga_config_sequencer_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 12
) (
  input  logic                    mode,
  input  logic [2:0]              idx,
  output logic [CONFIG_WIDTH-1:0] data
);

  always_comb begin
    data = CONFIG_WIDTH'(preset_value({mode, idx}));
  end

endmodule

// File: rtl/vga_config_sequencer.sv
// vga_config_sequencer: configuration master for the VGA timing controller.
// After reset and on each accepted start it writes one of two preset
// timing sets (8 registers) over the C port; between loads it passes the
// host write port H straight through. A per-write timeout aborts a load
// against a stalled controller and raises a sticky cfg_err.
// Ports:
//   Clk      - clock, rising edge
//   rst_n    - synchronous reset, active HIGH despite the name
//   start    - load request pulse, honoured only in IDLE
//   mode_sel - preset select, latched on reset release and accepted start
//   H        - host write port (slave side)
//   C        - configuration write port to the timing controller (master)
//   busy     - preset load in progress
//   done     - one-cycle pulse after a complete load
//   cfg_err  - sticky timeout flag
module vga_config_sequencer
  import vga_config_sequencer_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 12,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                   Clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode_sel,
  vga_config_sequencer_if.slave  H,
  vga_config_sequencer_if.master C,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic [CONFIG_WIDTH-1:0] rom_data;

  vga_timing_rom #(
    .CONFIG_WIDTH(CONFIG_WIDTH)
  ) u_rom (
    .mode (mode_q),
    .idx  (idx_q),
    .data (rom_data)
  );

  // Saturating stall count.
  always_comb begin
    cnt_inc = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (rst_n) begin
      state_q <= BOOT;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    done_d  = 1'b0;
    C.valid = 1'b0;
    C.addr  = '0;
    C.data  = '0;
    H.rdy   = 1'b0;
    busy    = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = LOAD;
        idx_d   = '0;
        cnt_d   = '0;
        mode_d  = mode_sel;
      end

      LOAD: begin
        busy    = 1'b1;
        C.valid = 1'b1;
        C.addr  = CONFIG_WIDTH'(idx_q);
        C.data  = rom_data;
        if (C.rdy) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_inc;
          // The edge where the stall count reaches TIMEOUT ends the load.
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end

      IDLE: begin
        if (start) begin
          // start wins over a concurrent host write; the host retries.
          state_d = LOAD;
          idx_d   = '0;
          cnt_d   = '0;
          mode_d  = mode_sel;
          err_d   = 1'b0;
        end else begin
          C.valid = H.valid;
          C.addr  = H.addr;
          C.data  = H.data;
          H.rdy   = C.rdy && H.valid;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_vga_config_sequencer.sv
module tb_vga_config_sequencer;

  typedef struct {
    int unsigned a;
    int unsigned d;
  } xfer_t;

  // Reference presets, indexed [register address].
  int unsigned ref_test [8] = '{1, 2, 7, 8, 1, 0, 10, 12};
  int unsigned ref_vga  [8] = '{48, 33, 16, 10, 96, 2, 800, 525};

  logic Clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode_sel = 1'b0;
  logic busy, done, cfg_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned rdy_mode = 0;  // 0: always ready, 1: random ~1-of-3, 2: ready only below addr 3
  xfer_t sb[$];

  vga_config_sequencer_if #(.WIDTH(12)) hif ();
  vga_config_sequencer_if #(.WIDTH(12)) cif ();

  vga_config_sequencer #(
    .CONFIG_WIDTH(12),
    .TIMEOUT(64)
  ) dut (
    .Clk      (Clk),
    .rst_n    (rst),
    .start    (start),
    .mode_sel (mode_sel),
    .H        (hif),
    .C        (cif),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 Clk = ~Clk;

  function automatic int unsigned ref_val(input int unsigned m, input int unsigned i);
    return (m != 0) ? ref_vga[i] : ref_test[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Controller ready driver.
  always @(posedge Clk) begin
    static int unsigned zero_run = 0;
    #1;
    case (rdy_mode)
      0: cif.rdy = 1'b1;
      1: begin
        if (zero_run >= 4 || $urandom_range(0, 2) == 0) begin
          cif.rdy = 1'b1;
          zero_run = 0;
        end else begin
          cif.rdy = 1'b0;
          zero_run++;
        end
      end
      default: cif.rdy = (cif.addr < 12'd3);
    endcase
  end

  // Monitor: scoreboard on every configuration-bus transfer plus protocol checks.
  logic        prev_stall = 1'b0;
  logic [11:0] prev_a = '0, prev_d = '0;
  always @(negedge Clk) begin
    xfer_t e;
    if (!rst) begin
      if (busy === 1'b1) chk("h_rdy_in_load", {31'd0, hif.rdy}, 32'd0);
      if (cif.valid === 1'b1 && cif.rdy === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_xfer: got addr %0d data %0d expected none at %0t",
                   cif.addr, cif.data, $time);
        end else begin
          e = sb.pop_front();
          chk("xfer_addr", {20'd0, cif.addr}, e.a);
          chk("xfer_data", {20'd0, cif.data}, e.d);
        end
      end
      if (prev_stall && busy === 1'b1) begin
        chk("hold_addr", {20'd0, cif.addr}, {20'd0, prev_a});
        chk("hold_data", {20'd0, cif.data}, {20'd0, prev_d});
      end
      if (done === 1'b1) chk("done_busy_low", {31'd0, busy}, 32'd0);
    end
    prev_stall <= !rst && busy && cif.valid && !cif.rdy;
    prev_a     <= cif.addr;
    prev_d     <= cif.data;
  end

  task automatic push_load(input int unsigned m, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back('{a: i, d: ref_val(m, i)});
  endtask

  // Issue start from IDLE (optionally with a colliding host write).
  task automatic start_load(input int unsigned m, input int unsigned n,
                            input bit host_en, input int unsigned ha, input int unsigned hd);
    @(posedge Clk); #1;
    start = 1'b1;
    mode_sel = m[0];
    push_load(m, n);
    if (host_en) begin
      hif.valid = 1'b1;
      hif.addr  = ha[11:0];
      hif.data  = hd[11:0];
      sb.push_back('{a: ha, d: hd});
    end
    @(negedge Clk);
    chk("start_c_valid", {31'd0, cif.valid}, 32'd0);
    chk("start_h_rdy", {31'd0, hif.rdy}, 32'd0);
    @(posedge Clk); #1;
    start = 1'b0;
    @(negedge Clk);
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_first_addr", {20'd0, cif.addr}, 32'd0);
    chk("load_err_clear", {31'd0, cfg_err}, 32'd0);
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== 1'b1) break;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_c_valid", {31'd0, cif.valid}, 32'd0);
    chk("rst_c_addr", {20'd0, cif.addr}, 32'd0);
    chk("rst_c_data", {20'd0, cif.data}, 32'd0);
    chk("rst_h_rdy", {31'd0, hif.rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got, got_h, saw_done;
    int unsigned m, stall, ha, hd;

    hif.valid = 1'b0;
    hif.addr  = '0;
    hif.data  = '0;
    cif.rdy   = 1'b1;

    // Reset and boot load in test mode with the controller always ready.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_reset_vals();
    @(posedge Clk); #1;
    rst = 1'b0;
    push_load(0, 8);
    @(posedge Clk);
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge Clk);
      chk("boot_busy", {31'd0, busy}, 32'd1);
      chk("boot_addr_seq", {20'd0, cif.addr}, k);
      chk("boot_no_early_done", {31'd0, done}, 32'd0);
    end
    @(negedge Clk);
    chk("boot_done", {31'd0, done}, 32'd1);
    chk("boot_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    chk("boot_done_single", {31'd0, done}, 32'd0);

    // 640x480 preset with a randomly stalling controller.
    rdy_mode = 1;
    start_load(1, 8, 1'b0, 0, 0);
    wait_done(got);
    chk("vga_load_done", {31'd0, got}, 32'd1);
    chk("vga_sb_empty", sb.size(), 32'd0);

    // Controller stops accepting at entry 3: timeout, cfg_err, no done.
    rdy_mode = 2;
    start_load(0, 3, 1'b0, 0, 0);
    stall = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (busy !== 1'b1) break;
      if (cif.addr == 12'd3) stall++;
    end
    chk("timeout_stall_cycles", stall, 32'd64);
    chk("timeout_cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("timeout_no_done", {31'd0, saw_done}, 32'd0);
    repeat (3) @(negedge Clk);
    chk("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);
    rdy_mode = 1;
    m = $urandom_range(0, 1);
    start_load(m, 8, 1'b0, 0, 0);
    wait_done(got);
    chk("after_err_done", {31'd0, got}, 32'd1);

    // Host pass-through in IDLE.
    rdy_mode = 0;
    @(posedge Clk); #1;
    hif.valid = 1'b1;
    hif.addr  = 12'd6;
    hif.data  = 12'd640;
    sb.push_back('{a: 6, d: 640});
    @(negedge Clk);
    chk("host_h_rdy", {31'd0, hif.rdy}, 32'd1);
    chk("host_c_valid", {31'd0, cif.valid}, 32'd1);
    chk("host_c_addr", {20'd0, cif.addr}, 32'd6);
    chk("host_c_data", {20'd0, cif.data}, 32'd640);
    rdy_mode = 1;
    for (int n = 0; n < 12; n++) begin
      @(posedge Clk); #1;
      ha = $urandom_range(0, 4095);
      hd = $urandom_range(0, 4095);
      hif.valid = 1'b1;
      hif.addr  = ha[11:0];
      hif.data  = hd[11:0];
      sb.push_back('{a: ha, d: hd});
      got_h = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge Clk);
        if (hif.rdy === 1'b1) begin
          got_h = 1'b1;
          break;
        end
      end
      chk("host_accepted", {31'd0, got_h}, 32'd1);
    end
    @(posedge Clk); #1;
    hif.valid = 1'b0;

    // start collides with a host write: start wins, host retries after the load.
    m = $urandom_range(0, 1);
    ha = $urandom_range(0, 4095);
    hd = $urandom_range(0, 4095);
    start_load(m, 8, 1'b1, ha, hd);
    got = 1'b0;
    got_h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clk);
      if (done === 1'b1) got = 1'b1;
      if (hif.rdy === 1'b1) begin
        got_h = 1'b1;
        break;
      end
    end
    @(posedge Clk); #1;
    hif.valid = 1'b0;
    chk("collide_load_done", {31'd0, got}, 32'd1);
    chk("collide_host_retry", {31'd0, got_h}, 32'd1);

    // Reset pulsed at entry 5 aborts the load; full boot load restarts.
    m = $urandom_range(0, 1);
    start_load(m, 5, 1'b0, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk); #1;
      if (busy === 1'b1 && cif.addr == 12'd5) begin
        got = 1'b1;
        break;
      end
    end
    chk("reached_entry5", {31'd0, got}, 32'd1);
    rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk_reset_vals();
    chk("abort_sb_empty", sb.size(), 32'd0);
    @(posedge Clk); #1;
    m = $urandom_range(0, 1);
    mode_sel = m[0];
    rst = 1'b0;
    push_load(m, 8);
    @(posedge Clk);
    @(negedge Clk);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_addr0", {20'd0, cif.addr}, 32'd0);
    wait_done(got);
    chk("restart_done", {31'd0, got}, 32'd1);

    repeat (2) @(negedge Clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
